button_conditioner: RTL and testbench

//   Input front end for the two player buttons (ui_in[0] = up/jump, ui_in[1] = down/duck).

---
 rtl/button_conditioner.sv | 199 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-button front end: 2-flop sync, tick-based debounce FSM per pin, press pulses, up-over-down priority.
// Optional long-hold pulse per button is compiled in when BUTTON_LONG_PRESS_EN is defined.
module button_conditioner #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int LONG_TICKS     = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       countdown_en,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    output logic       button_up,
    output logic       button_down,
    output logic       up_press,
    output logic       down_press,
    output logic [1:0] long_press
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ARM_PRESS = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_ARM_REL   = 2'd3;

    localparam logic [3:0] C_DEB_LOAD = 4'(DEBOUNCE_TICKS - 1);

    if ((DEBOUNCE_TICKS < 1) || (DEBOUNCE_TICKS > 15) ||
        (LONG_TICKS < 1) || (LONG_TICKS > 255)) begin : g_bad_cfg
        $error("button_conditioner: parameter out of range");
    end

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] w_lvl;
    logic [1:0] w_lvl_nxt;
`ifdef BUTTON_LONG_PRESS_EN
    logic [1:0] w_long;
`endif

    // two-flop synchroniser on the raw pins, bit 0 = up, bit 1 = down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {btn_down_raw, btn_up_raw};
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic       w_s;
        logic [1:0] r_state;
        logic [1:0] w_state_nxt;
        logic [3:0] r_cnt;
        logic [3:0] w_cnt_nxt;
        logic       r_lvl;
        logic       w_lvl_b_nxt;

        assign w_s = r_sync2[gi];

        // debounce FSM next-state; a synchronised input change beats a same-cycle tick
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_lvl_b_nxt = r_lvl;
            case (r_state)
                ST_IDLE: begin
                    w_lvl_b_nxt = 1'b0;
                    if (w_s) begin
                        w_cnt_nxt   = C_DEB_LOAD;
                        w_state_nxt = ST_ARM_PRESS;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ARM_PRESS: begin
                    w_lvl_b_nxt = 1'b0;
                    if (!w_s) begin
                        w_state_nxt = ST_IDLE;
                    end else if (countdown_en && (r_cnt == 4'd0)) begin
                        w_state_nxt = ST_PRESSED;
                        w_lvl_b_nxt = 1'b1;
                    end else if (countdown_en) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_state_nxt = ST_ARM_PRESS;
                    end
                end
                ST_PRESSED: begin
                    w_lvl_b_nxt = 1'b1;
                    if (!w_s) begin
                        w_cnt_nxt   = C_DEB_LOAD;
                        w_state_nxt = ST_ARM_REL;
                    end else begin
                        w_state_nxt = ST_PRESSED;
                    end
                end
                ST_ARM_REL: begin
                    w_lvl_b_nxt = 1'b1;
                    if (w_s) begin
                        w_state_nxt = ST_PRESSED;
                    end else if (countdown_en && (r_cnt == 4'd0)) begin
                        w_state_nxt = ST_IDLE;
                        w_lvl_b_nxt = 1'b0;
                    end else if (countdown_en) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        w_state_nxt = ST_ARM_REL;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_lvl_b_nxt = 1'b0;
                end
            endcase
        end

        // debounce FSM state, countdown and registered level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
                r_lvl   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_lvl   <= w_lvl_b_nxt;
            end
        end

        assign w_lvl[gi]     = r_lvl;
        assign w_lvl_nxt[gi] = w_lvl_b_nxt;

`ifdef BUTTON_LONG_PRESS_EN
        localparam logic [7:0] C_LONG    = 8'(LONG_TICKS);
        localparam logic [7:0] C_LONG_M1 = 8'(LONG_TICKS - 1);

        logic       w_held;
        logic [7:0] r_hold;
        logic       r_long;

        assign w_held = (r_state == ST_PRESSED) || (r_state == ST_ARM_REL);

        // hold counter saturates at LONG_TICKS so the pulse fires once per press
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold <= 8'd0;
                r_long <= 1'b0;
            end else if (!w_held) begin
                r_hold <= 8'd0;
                r_long <= 1'b0;
            end else if (countdown_en && (r_hold != C_LONG)) begin
                r_hold <= r_hold + 8'd1;
                r_long <= (r_hold == C_LONG_M1);
            end else begin
                r_hold <= r_hold;
                r_long <= 1'b0;
            end
        end

        assign w_long[gi] = r_long;
`endif
    end

    logic r_button_down;
    logic r_up_d;
    logic r_down_d;
    logic r_up_press;
    logic r_down_press;

    // masked down level and registered rising-edge pulses on both visible levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_button_down <= 1'b0;
            r_up_d        <= 1'b0;
            r_down_d      <= 1'b0;
            r_up_press    <= 1'b0;
            r_down_press  <= 1'b0;
        end else begin
            r_button_down <= w_lvl_nxt[1] & ~w_lvl_nxt[0];
            r_up_d        <= w_lvl[0];
            r_down_d      <= r_button_down;
            r_up_press    <= w_lvl[0] & ~r_up_d;
            r_down_press  <= r_button_down & ~r_down_d;
        end
    end

    assign button_up   = w_lvl[0];
    assign button_down = r_button_down;
    assign up_press    = r_up_press;
    assign down_press  = r_down_press;
`ifdef BUTTON_LONG_PRESS_EN
    assign long_press  = w_long;
`else
    assign long_press  = 2'b00;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: per-cycle scoreboard from a behavioural model plus
// hand-derived checks on pulse counts and levels at the key points of each scenario.
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       countdown_en = 1'b0;
    logic       btn_up_raw   = 1'b0;
    logic       btn_down_raw = 1'b0;
    logic       button_up;
    logic       button_down;
    logic       up_press;
    logic       down_press;
    logic [1:0] long_press;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_TICKS(DEB),
        .LONG_TICKS    (LONG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .countdown_en(countdown_en),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .button_up   (button_up),
        .button_down (button_down),
        .up_press    (up_press),
        .down_press  (down_press),
        .long_press  (long_press)
    );

    int n_tests = 0;
    int n_fail  = 0;

    string      tag_q[$];
    logic [5:0] exp_q[$];

    logic [1:0] m_s1, m_s2, m_lvl, m_armed, m_long;
    int         m_n[2];
    int         m_hold[2];
    logic       m_bu, m_bd, m_bu_d, m_bd_d, m_up_p, m_dn_p;
    int         up_cnt, dn_cnt, long0_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00; m_armed = 2'b00; m_long = 2'b00;
        m_n[0] = 0; m_n[1] = 0; m_hold[0] = 0; m_hold[1] = 0;
        m_bu = 1'b0; m_bd = 1'b0; m_bu_d = 1'b0; m_bd_d = 1'b0; m_up_p = 1'b0; m_dn_p = 1'b0;
    endtask

    // behavioural model of one clock edge: debounce counts ticks seen while s differs from the level
    task automatic model_edge();
        logic s;
        m_up_p = m_bu & ~m_bu_d;
        m_dn_p = m_bd & ~m_bd_d;
        m_bu_d = m_bu;
        m_bd_d = m_bd;
        for (int i = 0; i < 2; i++) begin
            m_long[i] = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
            if (!m_lvl[i]) begin
                m_hold[i] = 0;
            end else if (countdown_en && (m_hold[i] < LONG)) begin
                m_hold[i]++;
                m_long[i] = (m_hold[i] == LONG);
            end
`endif
            s = m_s2[i];
            if (!m_armed[i]) begin
                if (s != m_lvl[i]) begin
                    m_armed[i] = 1'b1;
                    m_n[i]     = 0;
                end
            end else if (s == m_lvl[i]) begin
                m_armed[i] = 1'b0;
            end else if (countdown_en) begin
                m_n[i]++;
                if (m_n[i] == DEB) begin
                    m_lvl[i]   = ~m_lvl[i];
                    m_armed[i] = 1'b0;
                end
            end
        end
        m_bu = m_lvl[0];
        m_bd = m_lvl[1] & ~m_lvl[0];
        m_s2 = m_s1;
        m_s1 = {btn_down_raw, btn_up_raw};
    endtask

    task automatic cycle(input logic en, input string tag);
        logic [5:0] obs;
        countdown_en = en;
        if (!rst_n) m_reset();
        else        model_edge();
        tag_q.push_back(tag);
        exp_q.push_back({m_bu, m_bd, m_up_p, m_dn_p, m_long});
        @(posedge clk);
        #1;
        obs = {button_up, button_down, up_press, down_press, long_press};
        check(tag_q.pop_front(), 32'(obs), 32'(exp_q.pop_front()));
        if (up_press === 1'b1)      up_cnt++;
        if (down_press === 1'b1)    dn_cnt++;
        if (long_press[0] === 1'b1) long0_cnt++;
    endtask

    task automatic run(input int n, input logic en, input string tag);
        for (int k = 0; k < n; k++) cycle(en, tag);
    endtask

    task automatic settle(input string tag);
        run(3, 1'b0, tag);
        run(DEB, 1'b1, tag);
        run(2, 1'b0, tag);
    endtask

    initial begin
        m_reset();
        up_cnt = 0; dn_cnt = 0; long0_cnt = 0;

        // 1: reset with both pins high, then acceptance after four ticks
        btn_up_raw = 1'b1; btn_down_raw = 1'b1;
        run(2, 1'b0, "rst_hold");
        rst_n = 1'b1;
        run(3, 1'b0, "t1_sync");
        run(DEB - 1, 1'b1, "t1_ticks");
        check("t1_not_yet", 32'(button_up), 32'd0);
        run(1, 1'b1, "t1_final_tick");
        check("t1_up_level", 32'(button_up), 32'd1);
        run(3, 1'b0, "t1_after");
        check("t1_up_press_cnt", 32'(up_cnt), 32'd1);
        check("t1_down_masked_cnt", 32'(dn_cnt), 32'd0);
        btn_up_raw = 1'b0; btn_down_raw = 1'b0;
        settle("t1_release");
        check("t1_released", 32'({button_up, button_down}), 32'd0);

        // 2: short pulse is discarded
        up_cnt = 0;
        btn_up_raw = 1'b1;
        run(3, 1'b0, "t2_sync");
        run(3, 1'b1, "t2_ticks");
        btn_up_raw = 1'b0;
        run(3, 1'b0, "t2_drop");
        run(DEB, 1'b1, "t2_more_ticks");
        check("t2_up_level", 32'(button_up), 32'd0);
        check("t2_up_press_cnt", 32'(up_cnt), 32'd0);

        // 3: held button survives a one-cycle low glitch
        btn_up_raw = 1'b1;
        settle("t3_press");
        check("t3_pressed", 32'(button_up), 32'd1);
        up_cnt = 0;
        btn_up_raw = 1'b0;
        run(1, 1'b1, "t3_glitch");
        btn_up_raw = 1'b1;
        run(6, 1'b1, "t3_recover");
        check("t3_still_up", 32'(button_up), 32'd1);
        check("t3_no_repress", 32'(up_cnt), 32'd0);
        btn_up_raw = 1'b0;
        settle("t3_release");
        check("t3_released", 32'(button_up), 32'd0);

        // 4: up masks down; releasing up re-exposes down with a press pulse
        up_cnt = 0; dn_cnt = 0;
        btn_down_raw = 1'b1;
        settle("t4_down");
        check("t4_down_level", 32'(button_down), 32'd1);
        check("t4_down_press_cnt", 32'(dn_cnt), 32'd1);
        btn_up_raw = 1'b1;
        run(3, 1'b0, "t4_up_sync");
        run(DEB, 1'b1, "t4_up_ticks");
        check("t4_mask_on_accept", 32'({button_up, button_down}), 32'b10);
        run(2, 1'b0, "t4_up_hold");
        btn_up_raw = 1'b0;
        run(3, 1'b0, "t4_up_rel_sync");
        run(DEB, 1'b1, "t4_up_rel_ticks");
        check("t4_unmask", 32'({button_up, button_down}), 32'b01);
        run(2, 1'b0, "t4_after");
        check("t4_down_press_cnt2", 32'(dn_cnt), 32'd2);
        check("t4_up_press_cnt", 32'(up_cnt), 32'd1);
        btn_down_raw = 1'b0;
        settle("t4_release");

        // 5: input drop coincident with the final tick reverts; four fresh ticks needed
        btn_up_raw = 1'b1;
        run(3, 1'b0, "t5_sync");
        run(DEB - 1, 1'b1, "t5_ticks");
        btn_up_raw = 1'b0;
        run(2, 1'b0, "t5_drop_sync");
        run(1, 1'b1, "t5_coincident");
        check("t5_tick_ignored", 32'(button_up), 32'd0);
        btn_up_raw = 1'b1;
        run(3, 1'b0, "t5_resync");
        run(DEB - 1, 1'b1, "t5_fresh");
        check("t5_not_yet", 32'(button_up), 32'd0);
        run(1, 1'b1, "t5_final");
        check("t5_accepted", 32'(button_up), 32'd1);
        btn_up_raw = 1'b0;
        settle("t5_release");

        // 6: long hold, then asynchronous reset in the middle of ARM_PRESS
        btn_up_raw = 1'b1;
        settle("t6_press");
        long0_cnt = 0;
        run(25, 1'b1, "t6_hold");
        run(2, 1'b0, "t6_after");
`ifdef BUTTON_LONG_PRESS_EN
        check("t6_long_cnt", 32'(long0_cnt), 32'd1);
`else
        check("t6_long_cnt", 32'(long0_cnt), 32'd0);
`endif
        btn_up_raw = 1'b0;
        settle("t6_release");
        btn_down_raw = 1'b1;
        settle("t6_down");
        btn_up_raw = 1'b1;
        run(3, 1'b0, "t6_arm_sync");
        run(2, 1'b1, "t6_arm_ticks");
        check("t6_pre_reset_down", 32'(button_down), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        tag_q.push_back("t6_async_reset");
        exp_q.push_back(6'd0);
        check(tag_q.pop_front(),
              32'({button_up, button_down, up_press, down_press, long_press}),
              32'(exp_q.pop_front()));
        run(2, 1'b1, "t6_in_reset");
        rst_n = 1'b1;
        run(3, 1'b0, "t6_post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
